// File: rtl/reg_scoreboard_if.sv
// Issue/release/status bundle between the decoder, writeback and reg_scoreboard.
// The decoder/writeback side uses the master modport; the scoreboard uses slave.
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  logic              iss_valid;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR-1:0]    rel_en;
  logic [NWR*AW-1:0] rel_addr;
  logic              flush;
  logic              hazard;
  logic              iss_ack;
  logic [NREG-1:0]   busy_mask;
  logic              err_uflow;

  modport master (
    output iss_valid, rd_en, rd_addr, wr_en, wr_addr, rel_en, rel_addr, flush,
    input  hazard, iss_ack, busy_mask, err_uflow
  );

  modport slave (
    input  iss_valid, rd_en, rd_addr, wr_en, wr_addr, rel_en, rel_addr, flush,
    output hazard, iss_ack, busy_mask, err_uflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters allocated at issue, released at writeback.
// Optional SB_WAW_CHECK_EN: also stall any write whose destination already has a pending write.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave sb
);

  // Sums hold a full counter plus every write port, with one bit of headroom.
  localparam int SW = CNT_W + $clog2(NWR + 1) + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SW-1:0]    sum_t;

  localparam sum_t CNT_MAX = sum_t'((1 << CNT_W) - 1);

  cnt_t            count_q [NREG];
  logic [NREG-1:0] busy_q;
  logic            uflow_q;

  logic [AW-1:0]   rd_a  [NRD];
  logic [AW-1:0]   wr_a  [NWR];
  logic [AW-1:0]   rel_a [NWR];

  sum_t            wr_req  [NREG];
  sum_t            rel_req [NREG];
  sum_t            up_sum  [NREG];
  logic [NREG-1:0] cnt_nz;

  logic            raw_hit;
  logic            ovf_hit;
  logic            waw_hit;
  logic            hazard_c;
  logic            iss_ack_c;

  cnt_t            count_d [NREG];
  logic [NREG-1:0] busy_d;
  logic            uflow_d;

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_a[i] = sb.rd_addr[i*AW +: AW];
    for (int p = 0; p < NWR; p++) begin
      wr_a[p]  = sb.wr_addr[p*AW +: AW];
      rel_a[p] = sb.rel_addr[p*AW +: AW];
    end
  end

  // Per-register port tallies; addresses >= NREG match no register and drop out here.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      // NOTE: blocking assignments in always_comb accumulate within the evaluation;
      // zeroing first also guarantees no latch is inferred.
      wr_req[r]  = '0;
      rel_req[r] = '0;
      cnt_nz[r]  = (count_q[r] != '0);
      for (int p = 0; p < NWR; p++) begin
        if (sb.wr_en[p] && (wr_a[p] == AW'(r)))   wr_req[r]  = wr_req[r] + sum_t'(1);
        if (sb.rel_en[p] && (rel_a[p] == AW'(r))) rel_req[r] = rel_req[r] + sum_t'(1);
      end
    end
  end

  // Stall terms look only at registered counts, so same-cycle releases never unblock.
  always_comb begin
    raw_hit = 1'b0;
    ovf_hit = 1'b0;
    waw_hit = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      for (int i = 0; i < NRD; i++) begin
        if (sb.rd_en[i] && (rd_a[i] == AW'(r)) && cnt_nz[r]) raw_hit = 1'b1;
      end
      if ((sum_t'(count_q[r]) + wr_req[r]) > CNT_MAX) ovf_hit = 1'b1;
`ifdef SB_WAW_CHECK_EN
      if ((wr_req[r] != '0) && cnt_nz[r]) waw_hit = 1'b1;
`else
      waw_hit = 1'b0;
`endif
    end
  end

  assign hazard_c  = rst & sb.iss_valid & (raw_hit | ovf_hit | waw_hit);
  assign iss_ack_c = rst & sb.iss_valid & ~hazard_c & ~sb.flush;

  assign sb.hazard    = hazard_c;
  assign sb.iss_ack   = iss_ack_c;
  assign sb.busy_mask = busy_q;
  assign sb.err_uflow = uflow_q;

  // Net update per register; an acked issue can never push a counter past CNT_MAX.
  always_comb begin
    uflow_d = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      up_sum[r] = sum_t'(count_q[r]) + (iss_ack_c ? wr_req[r] : '0);
      if (rel_req[r] > up_sum[r]) begin
        count_d[r] = '0;
        uflow_d    = 1'b1;
      end else begin
        count_d[r] = cnt_t'(up_sum[r] - rel_req[r]);
      end
      busy_d[r] = (count_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the counter array is state the stall logic reads every cycle,
      // so unlike a data RAM it must be reset.
      for (int r = 0; r < NREG; r++) count_q[r] <= '0;
      busy_q  <= '0;
      uflow_q <= 1'b0;
    end else if (sb.flush) begin
      for (int r = 0; r < NREG; r++) count_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) count_q[r] <= count_d[r];
      busy_q  <= busy_d;
      uflow_q <= uflow_q | uflow_d;
    end
  end

endmodule
